// File: rtl/otter_rf_pkg.sv
// rtl/otter_rf_pkg.sv - shared defaults and types for the scoreboarded OTTER register file
package otter_rf_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int CNT_W_DEF = 2;

  typedef logic [$clog2(NREGS_DEF)-1:0] rf_addr_t;
  typedef logic [XLEN_DEF-1:0]          rf_data_t;

endpackage

// File: rtl/rf_pending_ctr.sv
// rtl/rf_pending_ctr.sv - saturating pending-write counter for one architectural register
module rf_pending_ctr #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             busy,
  output logic             sat_drop
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // a reserve paired with a release in the same cycle cancels out
  assign sat_drop = inc && !dec && (cnt == CNT_MAX);
  assign busy     = (cnt != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && !dec && (cnt != CNT_MAX)) begin
      cnt <= cnt + CNT_W'(1);
    end else if (dec && !inc && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/otter_regfile_sb.sv
// rtl/otter_regfile_sb.sv - OTTER register file with RAW scoreboard; OTTER_RF_BYPASS_EN enables write-first bypass
module otter_regfile_sb
  import otter_rf_pkg::*;
#(
  parameter  int XLEN   = XLEN_DEF,
  parameter  int NREGS  = NREGS_DEF,
  parameter  int CNT_W  = CNT_W_DEF,
  localparam int ADDR_W = $clog2(NREGS)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] RF_RS1_ADR,
  input  logic [ADDR_W-1:0] RF_RS2_ADR,
  output logic [XLEN-1:0]   RF_RS1,
  output logic [XLEN-1:0]   RF_RS2,
  input  logic              RF_WE,
  input  logic [ADDR_W-1:0] RF_W_ADR,
  input  logic [XLEN-1:0]   RF_W_DATA,
  input  logic              RF_RSV_EN,
  input  logic [ADDR_W-1:0] RF_RSV_ADR,
  output logic              RF_RS1_BUSY,
  output logic              RF_RS2_BUSY,
  output logic              RF_STALL,
  output logic              RF_RSV_ERR
);

  logic [XLEN-1:0]              regs [NREGS];
  logic [NREGS-1:0][CNT_W-1:0]  cnt;
  logic [NREGS-1:0]             busy;
  logic [NREGS-1:0]             sat_drop;

  // regs[0] is only ever cleared, so it reads as zero without a special mux case
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (RF_WE && (RF_W_ADR != '0)) begin
      regs[RF_W_ADR] <= RF_W_DATA;
    end
  end

  assign cnt[0]      = '0;
  assign busy[0]     = 1'b0;
  assign sat_drop[0] = 1'b0;

  for (genvar r = 1; r < NREGS; r++) begin : g_ctr
    rf_pending_ctr #(.CNT_W(CNT_W)) u_ctr (
      .clk      (CLK),
      .rst      (RST),
      .inc      (RF_RSV_EN && (RF_RSV_ADR == ADDR_W'(r))),
      .dec      (RF_WE && (RF_W_ADR == ADDR_W'(r))),
      .cnt      (cnt[r]),
      .busy     (busy[r]),
      .sat_drop (sat_drop[r])
    );
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) RF_RSV_ERR <= 1'b0;
    else     RF_RSV_ERR <= |sat_drop;
  end

`ifdef OTTER_RF_BYPASS_EN
  logic rs1_match, rs2_match;

  assign rs1_match = RF_WE && (RF_W_ADR == RF_RS1_ADR) && (RF_RS1_ADR != '0);
  assign rs2_match = RF_WE && (RF_W_ADR == RF_RS2_ADR) && (RF_RS2_ADR != '0);

  assign RF_RS1 = rs1_match ? RF_W_DATA : regs[RF_RS1_ADR];
  assign RF_RS2 = rs2_match ? RF_W_DATA : regs[RF_RS2_ADR];

  // the last outstanding write retiring this cycle no longer blocks the reader
  assign RF_RS1_BUSY = busy[RF_RS1_ADR] && !(rs1_match && (cnt[RF_RS1_ADR] == CNT_W'(1)));
  assign RF_RS2_BUSY = busy[RF_RS2_ADR] && !(rs2_match && (cnt[RF_RS2_ADR] == CNT_W'(1)));
`else
  assign RF_RS1      = regs[RF_RS1_ADR];
  assign RF_RS2      = regs[RF_RS2_ADR];
  assign RF_RS1_BUSY = busy[RF_RS1_ADR];
  assign RF_RS2_BUSY = busy[RF_RS2_ADR];
`endif

  assign RF_STALL = RF_RS1_BUSY | RF_RS2_BUSY;

endmodule

// File: tb/tb_otter_regfile_sb.sv
// tb/tb_otter_regfile_sb.sv - bench for otter_regfile_sb, default and 64-bit/16-register builds
module tb_otter_regfile_sb;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  logic [4:0]  rs1_adr, rs2_adr, w_adr, rsv_adr;
  logic [31:0] rs1, rs2, w_data;
  logic        we, rsv_en, rs1_busy, rs2_busy, stall, rsv_err;

  logic [3:0]  x_rs1_adr, x_rs2_adr, x_w_adr, x_rsv_adr;
  logic [63:0] x_rs1, x_rs2, x_w_data;
  logic        x_we, x_rsv_en, x_rs1_busy, x_rs2_busy, x_stall, x_rsv_err;

  otter_regfile_sb dut (
    .CLK(clk), .RST(rst),
    .RF_RS1_ADR(rs1_adr), .RF_RS2_ADR(rs2_adr), .RF_RS1(rs1), .RF_RS2(rs2),
    .RF_WE(we), .RF_W_ADR(w_adr), .RF_W_DATA(w_data),
    .RF_RSV_EN(rsv_en), .RF_RSV_ADR(rsv_adr),
    .RF_RS1_BUSY(rs1_busy), .RF_RS2_BUSY(rs2_busy), .RF_STALL(stall), .RF_RSV_ERR(rsv_err)
  );

  otter_regfile_sb #(.XLEN(64), .NREGS(16)) dut_wide (
    .CLK(clk), .RST(rst),
    .RF_RS1_ADR(x_rs1_adr), .RF_RS2_ADR(x_rs2_adr), .RF_RS1(x_rs1), .RF_RS2(x_rs2),
    .RF_WE(x_we), .RF_W_ADR(x_w_adr), .RF_W_DATA(x_w_data),
    .RF_RSV_EN(x_rsv_en), .RF_RSV_ADR(x_rsv_adr),
    .RF_RS1_BUSY(x_rs1_busy), .RF_RS2_BUSY(x_rs2_busy), .RF_STALL(x_stall), .RF_RSV_ERR(x_rsv_err)
  );

  int total = 0;
  int bad   = 0;

  // reference: stored values and outstanding-write counts per register
  logic [31:0] mem [32];
  int          pend [32];
  logic        exp_err;
  localparam int PEND_MAX = 3;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      mem[i]  = '0;
      pend[i] = 0;
    end
    exp_err = 1'b0;
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a == 0) return '0;
`ifdef OTTER_RF_BYPASS_EN
    if (we && w_adr == a) return w_data;
`endif
    return mem[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    int p;
    p = (a == 0) ? 0 : pend[a];
`ifdef OTTER_RF_BYPASS_EN
    if (we && w_adr == a && p > 0) p--;
`endif
    return p != 0;
  endfunction

  task automatic model_edge();
    logic rsv, rel;
    rsv = rsv_en && rsv_adr != 0;
    rel = we && w_adr != 0;
    exp_err = 1'b0;
    if (rel) mem[w_adr] = w_data;
    if (rsv && rel && rsv_adr == w_adr) return;
    if (rsv) begin
      if (pend[rsv_adr] == PEND_MAX) exp_err = 1'b1;
      else pend[rsv_adr]++;
    end
    if (rel && pend[w_adr] > 0) pend[w_adr]--;
  endtask

  task automatic drive(input logic [4:0] a1, input logic [4:0] a2, input logic w,
                       input logic [4:0] wa, input logic [31:0] wd,
                       input logic r, input logic [4:0] ra);
    rs1_adr = a1; rs2_adr = a2; we = w; w_adr = wa; w_data = wd; rsv_en = r; rsv_adr = ra;
  endtask

  task automatic check_now();
    logic b1, b2;
    b1 = exp_busy(rs1_adr);
    b2 = exp_busy(rs2_adr);
    chk("rs1", 64'(rs1), 64'(exp_rd(rs1_adr)));
    chk("rs2", 64'(rs2), 64'(exp_rd(rs2_adr)));
    chk("rs1_busy", 64'(rs1_busy), 64'(b1));
    chk("rs2_busy", 64'(rs2_busy), 64'(b2));
    chk("stall", 64'(stall), 64'(b1 | b2));
    chk("rsv_err", 64'(rsv_err), 64'(exp_err));
  endtask

  task automatic step(input logic [4:0] a1, input logic [4:0] a2, input logic w,
                      input logic [4:0] wa, input logic [31:0] wd,
                      input logic r, input logic [4:0] ra);
    @(negedge clk);
    drive(a1, a2, w, wa, wd, r, ra);
    #1;
    check_now();
    @(posedge clk);
    model_edge();
  endtask

  initial begin
    rst = 1'b1;
    drive(5'd0, 5'd0, 1'b0, 5'd0, '0, 1'b0, 5'd0);
    x_rs1_adr = 4'd15; x_rs2_adr = 4'd0; x_we = 1'b0; x_w_adr = '0; x_w_data = '0;
    x_rsv_en = 1'b0; x_rsv_adr = '0;
    model_reset();

    // reset state while RST held
    @(posedge clk);
    #1;
    check_now();
    chk("wide_rs1_reset", x_rs1, 64'h0);
    @(negedge clk);
    rst = 1'b0;

    // reset mid-run: write x5, reserve x5, pulse RST between edges
    step(5'd5, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0);
    step(5'd5, 5'd0, 1'b0, 5'd0, '0, 1'b1, 5'd5);
    @(negedge clk);
    drive(5'd5, 5'd5, 1'b0, 5'd0, '0, 1'b0, 5'd0);
    #1;
    check_now();
    rst = 1'b1;
    #1;
    chk("mid_rst_rs1", 64'(rs1), 64'h0);
    chk("mid_rst_busy", 64'(rs1_busy), 64'h0);
    chk("mid_rst_stall", 64'(stall), 64'h0);
    model_reset();
    #1 rst = 1'b0;
    @(posedge clk);
    model_edge();
    step(5'd5, 5'd5, 1'b1, 5'd5, 32'h0, 1'b0, 5'd0);
    step(5'd5, 5'd5, 1'b0, 5'd0, '0, 1'b0, 5'd0);

    // x0 immunity
    step(5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0);
    step(5'd0, 5'd0, 1'b0, 5'd0, '0, 1'b0, 5'd0);

    // RAW stall on x7
    step(5'd7, 5'd0, 1'b0, 5'd0, '0, 1'b1, 5'd7);
    step(5'd7, 5'd0, 1'b0, 5'd0, '0, 1'b0, 5'd0);
    step(5'd7, 5'd0, 1'b0, 5'd0, '0, 1'b0, 5'd0);
    step(5'd7, 5'd7, 1'b1, 5'd7, 32'h1234, 1'b0, 5'd0);
    step(5'd7, 5'd0, 1'b0, 5'd0, '0, 1'b0, 5'd0);

    // WAW and simultaneous reserve/release on x3
    step(5'd3, 5'd0, 1'b0, 5'd0, '0, 1'b1, 5'd3);
    step(5'd3, 5'd0, 1'b0, 5'd0, '0, 1'b1, 5'd3);
    step(5'd3, 5'd0, 1'b1, 5'd3, 32'h11, 1'b1, 5'd3);
    step(5'd3, 5'd0, 1'b1, 5'd3, 32'h22, 1'b0, 5'd0);
    step(5'd3, 5'd0, 1'b1, 5'd3, 32'h33, 1'b0, 5'd0);
    step(5'd3, 5'd0, 1'b0, 5'd0, '0, 1'b0, 5'd0);

    // saturation on x9
    for (int i = 0; i < 4; i++) step(5'd9, 5'd0, 1'b0, 5'd0, '0, 1'b1, 5'd9);
    step(5'd9, 5'd0, 1'b0, 5'd0, '0, 1'b0, 5'd0);
    step(5'd0, 5'd9, 1'b0, 5'd0, '0, 1'b0, 5'd0);
    for (int i = 0; i < 4; i++) step(5'd9, 5'd9, 1'b1, 5'd9, 32'(i), 1'b0, 5'd0);
    step(5'd9, 5'd9, 1'b0, 5'd0, '0, 1'b0, 5'd0);

    // random traffic on a small register window to provoke hazards and saturation
    for (int i = 0; i < 400; i++) begin
      step(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)), $urandom,
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)));
    end

    // 64-bit, 16-register build
    @(negedge clk);
    drive(5'd0, 5'd0, 1'b0, 5'd0, '0, 1'b0, 5'd0);
    x_we = 1'b1; x_w_adr = 4'd15; x_w_data = 64'h0123456789ABCDEF;
    @(posedge clk);
    #1;
    x_we = 1'b0;
    chk("wide_rs1_x15", x_rs1, 64'h0123456789ABCDEF);
    chk("wide_rs2_x0", x_rs2, 64'h0);
    @(negedge clk);
    x_rsv_en = 1'b1; x_rsv_adr = 4'd15;
    @(posedge clk);
    #1;
    x_rsv_en = 1'b0;
    chk("wide_busy", 64'(x_rs1_busy), 64'h1);
    chk("wide_stall", 64'(x_stall), 64'h1);
    @(negedge clk);
    x_we = 1'b1; x_w_adr = 4'd15; x_w_data = 64'hFEDCBA9876543210;
    @(posedge clk);
    #1;
    x_we = 1'b0;
    chk("wide_rs1_after", x_rs1, 64'hFEDCBA9876543210);
    chk("wide_busy_after", 64'(x_rs1_busy), 64'h0);
    chk("wide_err", 64'(x_rsv_err), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
